// File: rtl/fib_tp_ctrl.sv
// Controller for an asynchronous two-phase dual-rail Fibonacci datapath: synchronizes the rails,
// decodes each completed token into a binary term, and acknowledges it. Optional watchdog: FIB_TP_CTRL_WDOG_EN.
module fib_tp_ctrl #(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 16,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      n_terms,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  fib_rst,
  output logic                  fib_ack,
  input  logic [WIDTH-1:0][1:0] fib_out,
  output logic [WIDTH-1:0]      term,
  output logic [CNT_W-1:0]      term_idx,
  output logic                  term_valid,
  input  logic                  term_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_WAIT,
    S_HOLD,
    S_ACK,
    S_DONE
  } state_t;

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

  state_t                  state_q, state_d;
  logic [WIDTH-1:0][1:0]   sync1, sync2, sync3;
  logic [WIDTH-1:0][1:0]   prev_rails;
  logic [WIDTH-1:0]        new_term;
  logic [SET_W-1:0]        settle_cnt;
  logic [CNT_W-1:0]        n_q;
  logic                    phase;
  logic                    zero_done_q;
  logic                    tok_complete;
  logic                    wd_expire;

  // A token is complete once every bit has flipped its rail parity away from the
  // current phase and the synchronized rails have held still for a cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    tok_complete = (sync2 == sync3);
    new_term     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((sync2[i][1] ^ sync2[i][0]) == phase) tok_complete = 1'b0;
      new_term[i] = sync2[i][1] ^ prev_rails[i][1];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start && (n_terms != '0)) state_d = S_SETTLE;
      S_SETTLE: if (settle_cnt == SETTLE_LAST) state_d = S_WAIT;
      S_WAIT: begin
        if (tok_complete)   state_d = S_HOLD;
        else if (wd_expire) state_d = S_IDLE;
      end
      S_HOLD:   if (term_ready) state_d = S_ACK;
      S_ACK:    state_d = (term_idx == n_q) ? S_DONE : S_WAIT;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the synchronizer flops are reset too, so stale rails cannot masquerade as a token after reset.
      sync1       <= '0;
      sync2       <= '0;
      sync3       <= '0;
      prev_rails  <= '0;
      phase       <= 1'b0;
      fib_ack     <= 1'b0;
      term        <= '0;
      term_idx    <= '0;
      n_q         <= '0;
      settle_cnt  <= '0;
      zero_done_q <= 1'b0;
    end else begin
      sync1       <= fib_out;
      sync2       <= sync1;
      sync3       <= sync2;
      zero_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          phase      <= 1'b0;
          fib_ack    <= 1'b0;
          prev_rails <= '0;
          settle_cnt <= '0;
          if (start) begin
            n_q         <= n_terms;
            term_idx    <= '0;
            zero_done_q <= (n_terms == '0);
          end
        end
        S_SETTLE: settle_cnt <= settle_cnt + 1'b1;
        S_WAIT: begin
          if (tok_complete) begin
            term       <= new_term;
            prev_rails <= sync2;
          end
        end
        S_HOLD: begin
          if (term_ready) begin
            fib_ack  <= ~fib_ack;
            phase    <= ~phase;
            term_idx <= term_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIB_TP_CTRL_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  // Held at zero outside WAIT, so it restarts from zero on every WAIT entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == S_WAIT) wd_cnt <= wd_cnt + 1'b1;
      else                   wd_cnt <= '0;
      if ((state_q == S_IDLE) && start) err_q <= 1'b0;
      else if (wd_expire)               err_q <= 1'b1;
    end
  end

  assign wd_expire = (state_q == S_WAIT) && !tok_complete && (wd_cnt == WD_LAST);
  assign err       = err_q;
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  assign busy       = (state_q != S_IDLE);
  assign fib_rst    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign term_valid = (state_q == S_HOLD);
  assign done       = (state_q == S_DONE) || zero_done_q;

endmodule

// File: tb/tb_fib_tp_ctrl.sv
// Self-checking bench for fib_tp_ctrl: a behavioural two-phase dual-rail Fibonacci source with
// per-bit skew, randomized backpressure, and terms checked against plain-arithmetic Fibonacci values.
module tb_fib_tp_ctrl;
  localparam int WIDTH   = 8;
  localparam int CNT_W   = 16;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 50;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [CNT_W-1:0]      n_terms;
  logic                  busy, done, err, fib_rst, fib_ack, term_valid;
  logic                  term_ready;
  logic [WIDTH-1:0][1:0] fib_out;
  logic [WIDTH-1:0]      term;
  logic [CNT_W-1:0]      term_idx;

  int n_checks = 0;
  int n_pass   = 0;

  // Source model knobs and status
  int m_skew        = 0;
  int m_stall_after = -1;
  bit m_emit        = 1'b0;
  int m_tok         = 0;

  always #5 clk = ~clk;

  fib_tp_ctrl #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .n_terms(n_terms),
    .busy(busy), .done(done), .err(err), .fib_rst(fib_rst), .fib_ack(fib_ack),
    .fib_out(fib_out), .term(term), .term_idx(term_idx),
    .term_valid(term_valid), .term_ready(term_ready)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic longint fib_ref(input int k);
    longint a = 0, b = 1, t;
    for (int j = 0; j < k; j++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a % (longint'(1) << WIDTH);
  endfunction

  // Datapath model: on release from reset it emits token 0, then one token per fib_ack toggle.
  // Each bit flips its one-rail for a 1 and its zero-rail for a 0, after 0..m_skew cycles.
  initial begin : source_model
    logic [WIDTH-1:0] cur, nxt;
    int               dly [WIDTH];
    bit               pend[WIDTH];
    bit               fresh, ack_seen, launch;
    fib_out  = '0;
    cur      = '0;
    nxt      = 1;
    fresh    = 1'b1;
    ack_seen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (fib_rst) begin
        fib_out  = '0;
        cur      = '0;
        nxt      = 1;
        fresh    = 1'b1;
        ack_seen = 1'b0;
        m_emit   = 1'b0;
        m_tok    = 0;
      end else begin
        launch = 1'b0;
        if (fresh) begin
          fresh  = 1'b0;
          launch = 1'b1;
        end else if (!m_emit && (fib_ack != ack_seen)) begin
          ack_seen   = fib_ack;
          {cur, nxt} = {nxt, cur + nxt};
          m_tok++;
          launch = (m_stall_after < 0) || (m_tok <= m_stall_after);
        end
        if (launch) begin
          for (int i = 0; i < WIDTH; i++) begin
            pend[i] = 1'b1;
            dly[i]  = int'($urandom_range(m_skew, 0));
          end
          m_emit = 1'b1;
        end
        if (m_emit) begin
          m_emit = 1'b0;
          for (int i = 0; i < WIDTH; i++) begin
            if (pend[i]) begin
              if (dly[i] == 0) begin
                if (cur[i]) fib_out[i][1] = ~fib_out[i][1];
                else        fib_out[i][0] = ~fib_out[i][0];
                pend[i] = 1'b0;
              end else begin
                dly[i]--;
                m_emit = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // One run: start with n terms, consume them, optionally stall at one index,
  // inject stray starts, or pulse rst while a given index is being held.
  task automatic run(input int n, input int skew, input int stall_idx, input int stall_len,
                     input bit rnd, input int rst_idx, input string tag);
    int acc = 0, dones = 0, stall_cnt = 0, cyc = 0;
    bit prev_valid = 1'b0, finished = 1'b0;
    m_skew = skew;
    @(negedge clk);
    start   = 1'b1;
    n_terms = CNT_W'(n);
    while (cyc < 3000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) dones++;
      else if (dones > 0) begin
        finished = 1'b1;
        break;
      end
      check({tag, "_ack_parity"}, fib_ack, acc & 1);
      if (n == 0) begin
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fib_rst"}, fib_rst, 1);
      end
      if (term_valid) begin
        if (!prev_valid) check({tag, "_settled"}, m_emit, 0);
        check({tag, "_term"}, term, fib_ref(acc));
        check({tag, "_idx"}, term_idx, acc);
        if (acc == rst_idx) begin
          rst        = 1'b1;
          term_ready = 1'b0;
          #1;
          check({tag, "_rst_busy"}, busy, 0);
          check({tag, "_rst_fib_rst"}, fib_rst, 1);
          check({tag, "_rst_ack"}, fib_ack, 0);
          check({tag, "_rst_valid"}, term_valid, 0);
          check({tag, "_rst_term"}, term, 0);
          check({tag, "_rst_idx"}, term_idx, 0);
          check({tag, "_rst_done"}, done, 0);
          check({tag, "_rst_err"}, err, 0);
          @(negedge clk);
          check({tag, "_rst_no_done"}, done, 0);
          rst = 1'b0;
          return;
        end
      end
      prev_valid = term_valid;
      if (term_valid && (stall_idx == acc) && (stall_cnt < stall_len)) begin
        term_ready = 1'b0;
        stall_cnt++;
      end else begin
        term_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      end
      if (rnd && ($urandom_range(7, 0) == 0)) begin
        start   = 1'b1;
        n_terms = CNT_W'($urandom_range(3, 0));
      end
      if (term_valid && term_ready) acc++;
    end
    check({tag, "_finished"}, finished, 1);
    check({tag, "_done_count"}, dones, 1);
    check({tag, "_terms"}, acc, n);
    check({tag, "_end_busy"}, busy, 0);
    check({tag, "_end_fib_rst"}, fib_rst, 1);
    check({tag, "_end_err"}, err, 0);
    if (stall_len > 0) check({tag, "_stall_len"}, stall_cnt, stall_len);
  endtask

  initial begin : main
    rst        = 1'b1;
    start      = 1'b0;
    n_terms    = '0;
    term_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_fib_rst", fib_rst, 1);
    check("reset_fib_ack", fib_ack, 0);
    check("reset_valid", term_valid, 0);
    check("reset_term", term, 0);
    check("reset_idx", term_idx, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(6, 0, -1, 0, 1'b0, -1, "basic");
    run(6, 0, 2, 10, 1'b0, -1, "stall");
    run(6, 7, -1, 0, 1'b0, -1, "skew");
    run(6, 0, -1, 0, 1'b0, 3, "midrst");
    repeat (3) @(negedge clk);
    run(2, 0, -1, 0, 1'b0, -1, "post_rst");
    run(0, 0, -1, 0, 1'b0, -1, "zero");
    for (int r = 0; r < 6; r++)
      run(int'($urandom_range(15, 1)), int'($urandom_range(7, 0)), -1, 0, 1'b1, -1, "rand");

`ifdef FIB_TP_CTRL_WDOG_EN
    begin : wdog_test
      int cyc = 0, t_ack = -1, t_err = -1, acc = 0, dones = 0;
      m_stall_after = 1;
      m_skew        = 0;
      @(negedge clk);
      start   = 1'b1;
      n_terms = CNT_W'(6);
      while (t_err < 0 && cyc < 400) begin
        @(negedge clk);
        start = 1'b0;
        cyc++;
        if (done) dones++;
        if (err) t_err = cyc;
        else begin
          term_ready = 1'b1;
          if (term_valid) begin
            acc++;
            if (acc == 2) t_ack = cyc;
          end
        end
      end
      // WAIT is entered two edges after the last handshake; err follows TIMEOUT cycles later.
      check("wdog_latency", t_err - t_ack, TIMEOUT + 2);
      check("wdog_busy", busy, 0);
      check("wdog_fib_rst", fib_rst, 1);
      check("wdog_no_done", dones, 0);
      check("wdog_terms", acc, 2);
      m_stall_after = -1;
      @(negedge clk);
      check("wdog_sticky", err, 1);
    end
    run(1, 0, -1, 0, 1'b0, -1, "after_wdog");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
